// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: bus widths, chip-enable encoding, PC constants
// and the {pc, inst} entry carried through the prefetch FIFO.
package inst_fetch_pkg;

  localparam int unsigned InstAddrWidth = 32;
  localparam int unsigned InstWidth     = 32;

  typedef logic [InstAddrWidth-1:0] inst_addr_bus_t;
  typedef logic [InstWidth-1:0]     inst_bus_t;

  typedef enum logic {
    ChipDisable = 1'b0,
    ChipEnable  = 1'b1
  } chip_en_e;

  localparam int unsigned    InstFifoDepth = 2;
  localparam inst_addr_bus_t PcStep        = 32'd4;
  localparam inst_addr_bus_t ResetPc       = 32'h0000_0000;

  typedef struct packed {
    inst_addr_bus_t pc;
    inst_bus_t      inst;
  } fetch_entry_t;

  // Word-align a redirect target by clearing the byte-offset bits.
  function automatic inst_addr_bus_t align_pc(input inst_addr_bus_t addr);
    return addr & ~inst_addr_bus_t'(3);
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous prefetch FIFO of {pc, inst} entries with flush; head reads as
// zero while empty.
module inst_fifo
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = InstFifoDepth
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wr_data,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  fetch_entry_t    mem [DEPTH];
  logic [PtrW-1:0] rd_ptr;
  logic [PtrW-1:0] wr_ptr;
  logic [CntW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_data;
  end

  always_comb begin
    full  = (count == CntW'(DEPTH));
    empty = (count == '0);
    head  = empty ? '0 : mem[rd_ptr];
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction ROM and buffers
// fetched {pc, inst} pairs for decode; execute redirects flush and reload the PC.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned    DEPTH    = InstFifoDepth,
  parameter inst_addr_bus_t RESET_PC = ResetPc
) (
  input  logic           clk,
  input  logic           rst,
  output logic           rom_ce_o,
  output inst_addr_bus_t rom_addr_o,
  input  inst_bus_t      rom_data_i,
  input  logic           branch_flag_i,
  input  inst_addr_bus_t branch_target_i,
  input  logic           id_ready_i,
  output logic           id_valid_o,
  output inst_addr_bus_t id_pc_o,
  output inst_bus_t      id_inst_o
);

  chip_en_e       ce_q;
  inst_addr_bus_t pc;
  logic           fifo_full;
  logic           fifo_empty;
  logic           push;
  logic           pop;
  logic           flush;
  fetch_entry_t   wr_entry;
  fetch_entry_t   head;

  always_ff @(posedge clk) begin
    if (rst) ce_q <= ChipDisable;
    else     ce_q <= ChipEnable;
  end

  // Redirect wins over push; a full FIFO still accepts a push when decode pops.
  always_comb begin
    rom_ce_o = (ce_q == ChipEnable);
    pop      = !fifo_empty && id_ready_i;
    flush    = rom_ce_o && branch_flag_i;
    push     = rom_ce_o && !branch_flag_i && (!fifo_full || pop);
    wr_entry = '{pc: pc, inst: rom_data_i};
  end

  always_ff @(posedge clk) begin
    if (rst)        pc <= RESET_PC;
    else if (flush) pc <= align_pc(branch_target_i);
    else if (push)  pc <= pc + PcStep;
  end

  inst_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .push   (push),
    .pop    (pop),
    .wr_data(wr_entry),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (head)
  );

  always_comb begin
    rom_addr_o = pc;
    id_valid_o = !fifo_empty;
    id_pc_o    = head.pc;
    id_inst_o  = head.inst;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage between the core's PC logic and the instruction ROM. Owns the program counter, drives the ROM's chip-enable and address, captures each returned instruction together with its PC into a small prefetch FIFO, and presents them to the decode stage over a valid/ready handshake. Branch redirects from execute flush the FIFO and reload the PC.

## Interface

Parameters:
- `DEPTH`, 2: prefetch FIFO entries; power of two, minimum 2.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; low 2 bits are zero.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rom_ce_o`  out  1  ROM chip enable (`ChipEnable`/`ChipDisable`).
- `rom_addr_o`  out  `InstAddrBus` (32)  fetch address; equals current PC.
- `rom_data_i`  in  `InstBus` (32)  ROM data; combinational from `rom_addr_o` in the same cycle.
- `branch_flag_i`  in  1  redirect request from execute.
- `branch_target_i`  in  32  redirect PC.
- `id_ready_i`  in  1  decode accepts the head entry this cycle.
- `id_valid_o`  out  1  head entry valid.
- `id_pc_o`  out  32  PC of head entry.
- `id_inst_o`  out  32  instruction of head entry.

## Operation

- Reset (`rst`=1 at an edge): `pc`←`RESET_PC`, `rom_ce_o`←0, FIFO count←0. Outputs after reset: `rom_ce_o`=0, `rom_addr_o`=`RESET_PC`, `id_valid_o`=0, `id_pc_o`=0, `id_inst_o`=0 (head data forced to zero when empty).
- `rom_ce_o` is registered; it goes to 1 at the first edge with `rst`=0 and stays 1 until the next reset.
- pop = `id_valid_o` & `id_ready_i`.
- push = `rom_ce_o` & !`branch_flag_i` & (count < `DEPTH` | pop). A push writes {`pc`, `rom_data_i`} and advances `pc` by 4.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 → 32'h0000_0000.
- Redirect (`branch_flag_i`=1, `rom_ce_o`=1): at the edge FIFO count←0 (all entries, including any being popped, discarded from the fetch side; decode's own pop in that cycle still counts as consumed), `pc`←{`branch_target_i`[31:2], 2'b00}, no push. Redirect has priority over push and over back-pressure.
- Redirect while `rom_ce_o`=0: ignored.
- Simultaneous push and pop when full: both occur, count unchanged.
- Head data held stable while `id_valid_o`=1 and `id_ready_i`=0.
- No FSM beyond the reset/running distinction carried by `rom_ce_o`; sequential state is `pc`, `rom_ce_o`, FIFO storage, read/write pointers, and count.

## Timing

- Edge E0: first edge with `rst`=0 → `rom_ce_o`=1, `rom_addr_o`=`RESET_PC`.
- Edge E1: push of `RESET_PC` entry → `id_valid_o`=1 after E1 (fetch-to-decode latency 1 cycle after enable).
- With `id_ready_i` held at 1: one instruction per cycle, consecutive PCs.
- With `id_ready_i`=0: FIFO fills in `DEPTH` cycles; `pc` then holds and `rom_addr_o` repeats the next unfetched address.
- Redirect at edge Eb: `id_valid_o`=0 for the cycle after Eb; target instruction valid after Eb+1.
- Reset asserted mid-stream: at that edge, all state returns to reset values; in-flight entries are lost.

## Structure

- Shared package / `defines.v` additions: `InstFifoDepth` (2), `PcStep` (4), and `ResetPc`. Reuse the existing `InstAddrBus`, `InstBus`, `ChipEnable`, and `ChipDisable` definitions.
- Sub-module `inst_fifo`: synchronous FIFO of width 64 ({pc, inst}) with `flush`, `push`, and `pop` inputs and `full`, `empty`, and head outputs. `inst_fetch` contains the PC register, enable register, and push/redirect control.

## Test plan

- Reset then run with `id_ready_i`=1, ROM[i]=32'h1000_0000+i → `id_valid_o` rises after E1; (`id_pc_o`,`id_inst_o`) = (0,32'h1000_0000),(4,32'h1000_0001),… one per cycle.
- Hold `id_ready_i`=0 for 5 cycles after start → count saturates at 2; `rom_addr_o` holds at 8; release → PCs 0, 4, 8, 12 in order, none lost or duplicated.
- `branch_flag_i`=1 with `branch_target_i`=32'h0000_0042 while FIFO is full → next cycle `id_valid_o`=0 and `rom_addr_o`=32'h40; following cycle head `id_pc_o`=32'h40.
- Full FIFO with `id_ready_i`=1 and push in same cycle → count stays 2, sustained throughput of 1/cycle.
- PC near top: redirect to 32'hFFFF_FFF8 → entries at FFFF_FFF8, FFFF_FFFC, then 0000_0000.
- Assert `rst` for one cycle mid-stream with 2 entries buffered → next cycle `id_valid_o`=0, `rom_ce_o`=0, `rom_addr_o`=`RESET_PC`; the restart sequence matches the first scenario.
